// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small transmit FIFO.
// Frames are start, LSB-first data, optional parity and stop bits, each lasting one tx_clk_en interval.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_BITS-1:0]                tx_data,
    input  logic                                write_enable,
    input  logic                                tx_clk_en,
    input  logic                                state_clear,
    output logic                                tx,
    output logic                                busy,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
    output logic                                overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state, state_n;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
    logic                   stop_cnt, stop_cnt_n;
    logic                   par, par_n;
    logic [PTR_W-1:0]       wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0]       count_n;
    logic                   tx_n, busy_n, full_n, empty_n, overflow_n;
    logic [DATA_BITS-1:0]   head_c;
    logic                   frame_end_c, pop_c, push_c, drop_c;

    // FIFO storage; pointers carry the reset, so the array needs none
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            par      <= par_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count    <= count_n;
            tx       <= tx_n;
            busy     <= busy_n;
            full     <= full_n;
            empty    <= empty_n;
            overflow <= overflow_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        par_n      = par;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        count_n    = count;
        tx_n       = tx;
        overflow_n = overflow;

        head_c      = mem[rd_ptr];
        frame_end_c = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));
        // A pop only happens when a new frame can start on this tick
        pop_c  = tx_clk_en && !empty && ((state == IDLE) || frame_end_c);
        push_c = write_enable && (!full || pop_c);
        drop_c = write_enable && full && !pop_c;

        if (tx_clk_en) begin
            case (state)
                IDLE: begin
                    tx_n = 1'b1;
                end
                START: begin
                    state_n   = DATA;
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = '0;
                end
                DATA: begin
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        if (PARITY_MODE != 0) begin
                            state_n = PARITY;
                            tx_n    = par;
                        end else begin
                            state_n    = STOP;
                            tx_n       = 1'b1;
                            stop_cnt_n = 1'b0;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end
                PARITY: begin
                    state_n    = STOP;
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                end
                STOP: begin
                    if (frame_end_c) begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            endcase

            // Load the next word; overrides the IDLE/STOP defaults above
            if (pop_c) begin
                state_n = START;
                tx_n    = 1'b0;
                shreg_n = head_c;
                par_n   = (^head_c) ^ 1'(PARITY_MODE == 2);
            end
        end

        if (pop_c) begin
            rd_ptr_n = rd_ptr + PTR_W'(1);
        end
        if (push_c) begin
            wr_ptr_n = wr_ptr + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase

        full_n  = (count_n == CNT_W'(FIFO_DEPTH));
        empty_n = (count_n == '0);
        busy_n  = (state_n != IDLE) || (count_n != '0);

        if (drop_c) begin
            overflow_n = 1'b1;
        end else if (state_clear) begin
            overflow_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based line model checks the default instance every cycle,
// plus vector tables and hand sequences (two extra instances cover other frame formats).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       write_enable, tx_clk_en, state_clear;

    logic       tx0, busy0, full0, empty0, ovf0;
    logic [2:0] count0;
    logic       tx1, busy1, full1, empty1, ovf1;
    logic [2:0] count1;
    logic       tx2, busy2, full2, empty2, ovf2;
    logic [2:0] count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .write_enable(write_enable),
        .tx_clk_en(tx_clk_en), .state_clear(state_clear), .tx(tx0), .busy(busy0),
        .full(full0), .empty(empty0), .count(count0), .overflow(ovf0)
    );

    uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .write_enable(write_enable),
        .tx_clk_en(tx_clk_en), .state_clear(state_clear), .tx(tx1), .busy(busy1),
        .full(full1), .empty(empty1), .count(count1), .overflow(ovf1)
    );

    uart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .write_enable(write_enable),
        .tx_clk_en(tx_clk_en), .state_clear(state_clear), .tx(tx2), .busy(busy2),
        .full(full2), .empty(empty2), .count(count2), .overflow(ovf2)
    );

    // Reference model of the default instance: word queue plus the bits still to be sent
    localparam int M_DEPTH = 4;
    logic [7:0] m_fifo[$];
    logic       m_frame[$];
    logic       m_tx     = 1'b1;
    logic       m_ovf    = 1'b0;
    logic       m_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic we, input logic [7:0] d,
                                input logic tk, input logic cl);
        logic       pop, was_full;
        logic [7:0] w;
        if (r) begin
            m_fifo.delete();
            m_frame.delete();
            m_tx = 1'b1; m_ovf = 1'b0; m_active = 1'b0;
            return;
        end
        was_full = (m_fifo.size() == M_DEPTH);
        pop = tk && (m_frame.size() == 0) && (m_fifo.size() > 0);
        if (tk) begin
            if (m_frame.size() != 0) begin
                m_tx = m_frame.pop_front();
            end else if (m_fifo.size() > 0) begin
                w = m_fifo.pop_front();
                m_frame.push_back(1'b0);
                for (int i = 0; i < 8; i++) m_frame.push_back(w[i]);
                m_frame.push_back(^w);
                m_frame.push_back(1'b1);
                m_tx = m_frame.pop_front();
                m_active = 1'b1;
            end else begin
                m_tx = 1'b1;
                m_active = 1'b0;
            end
        end
        if (we) begin
            if (!was_full || pop) m_fifo.push_back(d);
            else m_ovf = 1'b1;
        end else if (cl) begin
            m_ovf = 1'b0;
        end
        if (we && was_full && !pop) m_ovf = 1'b1;
        else if (cl) m_ovf = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, compare the default instance after the edge
    task automatic step(input logic r, input logic we, input logic [7:0] d,
                        input logic tk, input logic cl);
        rst = r; write_enable = we; tx_data = d; tx_clk_en = tk; state_clear = cl;
        @(posedge clk);
        model_update(r, we, d, tk, cl);
        #1;
        check("model.tx", 32'(tx0), 32'(m_tx));
        check("model.busy", 32'(busy0), 32'(m_active || (m_fifo.size() > 0)));
        check("model.count", 32'(count0), 32'(m_fifo.size()));
        check("model.full", 32'(full0), 32'(m_fifo.size() == M_DEPTH));
        check("model.empty", 32'(empty0), 32'(m_fifo.size() == 0));
        check("model.overflow", 32'(ovf0), 32'(m_ovf));
    endtask

    typedef struct {
        logic       r, we;
        logic [7:0] d;
        logic       tk, cl;
        logic       e_tx, e_busy;
        logic [2:0] e_cnt;
        logic       e_full, e_empty, e_ovf;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic exp34[11];
        logic exp35[10];

        rst = 1'b1; write_enable = 1'b0; tx_data = '0; tx_clk_en = 1'b0; state_clear = 1'b0;

        // Fill, overflow, clear, full push+pop, coincident drop and clear, reset dominance
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

        exp34 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp35 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].we, tbl[i].d, tbl[i].tk, tbl[i].cl);
            check($sformatf("vec%0d.tx", i), 32'(tx0), 32'(tbl[i].e_tx));
            check($sformatf("vec%0d.busy", i), 32'(busy0), 32'(tbl[i].e_busy));
            check($sformatf("vec%0d.count", i), 32'(count0), 32'(tbl[i].e_cnt));
            check($sformatf("vec%0d.full", i), 32'(full0), 32'(tbl[i].e_full));
            check($sformatf("vec%0d.empty", i), 32'(empty0), 32'(tbl[i].e_empty));
            check($sformatf("vec%0d.overflow", i), 32'(ovf0), 32'(tbl[i].e_ovf));
        end

        // Single 0x01 frame with even parity, then back to idle
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("frame01.bit%0d", i), 32'(tx0), 32'(exp34[i]));
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check($sformatf("frame01.hold%0d", i), 32'(tx0), 32'(exp34[i]));
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("frame01.busy_end", 32'(busy0), 32'd0);
        check("frame01.tx_end", 32'(tx0), 32'd1);

        // Back-to-back frames: 0x0B start bit directly after 0x0A stop bit
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h0A, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
        for (int i = 3; i < 11; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("b2b.stop_bit", 32'(tx0), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("b2b.second_start", 32'(tx0), 32'd0);
        check("b2b.busy", 32'(busy0), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("b2b.second_bit0", 32'(tx0), 32'd1);

        // 7 data bits, odd parity: 0x03 gives a 10-tick frame with parity 1
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("odd7.bit%0d", i), 32'(tx1), 32'(exp35[i]));
            check($sformatf("odd7.busy%0d", i), 32'(busy1), 32'd1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("odd7.busy_end", 32'(busy1), 32'd0);

        // Two stop bits, reset during the 4th data bit flushes FIFO and aborts the frame
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("abort.count_before", 32'(count2), 32'd1);
        check("abort.busy_before", 32'(busy2), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("abort.tx", 32'(tx2), 32'd1);
        check("abort.count", 32'(count2), 32'd0);
        check("abort.empty", 32'(empty2), 32'd1);
        check("abort.busy", 32'(busy2), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("abort.idle%0d", i), 32'(tx2), 32'd1);
        end

        // Randomized traffic against the model
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 3), 8'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
